// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I opcode/funct3/funct7[5] into a 4-bit ALU code, picks operands, registers into ID/EX.
// Latency: 1 cycle from in_valid&&in_ready to out_valid; throughput 1 op/cycle.
// Backpressure: in_ready = !out_valid || out_ready; a held op stays frozen until consumed; flush squashes it.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   in_valid/in_ready            decode-side handshake
//   opcode, funct3, funct7b5     instruction fields used for decode
//   rs1_data, rs2_data, imm, pc  operand sources
//   flush                        squash held and incoming instruction
//   out_valid/out_ready          execute-side handshake
//   alu_f, op_a, op_b            registered ALU function code and operands
//   store_data                   registered rs2 passthrough
//   illegal                      registered undecodable-instruction flag
module alu_issue_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_f,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] store_data,
  output logic             illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] F_AND  = 4'd0;
  localparam logic [3:0] F_OR   = 4'd1;
  localparam logic [3:0] F_ADD  = 4'd2;
  localparam logic [3:0] F_XOR  = 4'd3;
  localparam logic [3:0] F_SRL  = 4'd4;
  localparam logic [3:0] F_SLL  = 4'd5;
  localparam logic [3:0] F_SUB  = 4'd6;
  localparam logic [3:0] F_SLT  = 4'd7;
  localparam logic [3:0] F_SRA  = 4'd8;
  localparam logic [3:0] F_SLTU = 4'd9;

  logic [3:0]       dec_f;
  logic [WIDTH-1:0] dec_a;
  logic [WIDTH-1:0] dec_b;
  logic             dec_ill;
  logic [3:0]       arith_f;

  logic             out_valid_q, out_valid_d;
  logic [3:0]       alu_f_q, alu_f_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] store_data_q, store_data_d;
  logic             illegal_q, illegal_d;
  logic             load;

  // funct3 table shared by OP and OP-IMM; SUB is only selectable from OP.
  always_comb begin
    arith_f = F_ADD;
    unique case (funct3)
      3'b000: arith_f = (opcode == OPC_OP && funct7b5) ? F_SUB : F_ADD;
      3'b001: arith_f = F_SLL;
      3'b010: arith_f = F_SLT;
      3'b011: arith_f = F_SLTU;
      3'b100: arith_f = F_XOR;
      3'b101: arith_f = funct7b5 ? F_SRA : F_SRL;
      3'b110: arith_f = F_OR;
      3'b111: arith_f = F_AND;
      default: arith_f = F_ADD;
    endcase
  end

  always_comb begin
    dec_f   = F_ADD;
    dec_a   = rs1_data;
    dec_b   = imm;
    dec_ill = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_f   = arith_f;
        dec_b   = rs2_data;
        dec_ill = funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101);
      end
      OPC_OP_IMM: begin
        dec_f = arith_f;
        // Shift-immediates carry the shift amount in imm[4:0]; upper bits hold funct7.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_b = {{(WIDTH-5){1'b0}}, imm[4:0]};
        end
        dec_ill = (funct3 == 3'b001) && funct7b5;
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        dec_f = F_ADD;
      end
      OPC_AUIPC: begin
        dec_a = pc;
      end
      OPC_LUI: begin
        dec_a = '0;
      end
      OPC_JAL: begin
        dec_a = pc;
        dec_b = WIDTH'(4);
      end
      OPC_BRANCH: begin
        dec_b = rs2_data;
        unique case (funct3[2:1])
          2'b00: dec_f = F_SUB;
          2'b10: dec_f = F_SLT;
          2'b11: dec_f = F_SLTU;
          default: begin
            dec_f   = F_ADD;
            dec_ill = 1'b1;
          end
        endcase
      end
      default: begin
        // Unknown opcode still issues so execute can raise the trap.
        dec_f   = F_ADD;
        dec_a   = '0;
        dec_b   = '0;
        dec_ill = 1'b1;
      end
    endcase
  end

  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    alu_f_d      = alu_f_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    store_data_d = store_data_q;
    illegal_d    = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
      illegal_d   = 1'b0;
    end else if (load) begin
      out_valid_d  = 1'b1;
      alu_f_d      = dec_f;
      op_a_d       = dec_a;
      op_b_d       = dec_b;
      store_data_d = rs2_data;
      illegal_d    = dec_ill;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      alu_f_q      <= F_ADD;
      op_a_q       <= '0;
      op_b_q       <= '0;
      store_data_q <= '0;
      illegal_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      alu_f_q      <= alu_f_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      store_data_q <= store_data_d;
      illegal_q    <= illegal_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_f      = alu_f_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign store_data = store_data_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed vectors, expected results queued at accept, monitor compares at transfer.
// Latency: DUT result is checked one cycle after acceptance, on the negedge before the consuming edge.
// Backpressure: out_ready is toggled by the stimulus to exercise stalls and flush of a held op.
module tb_alu_issue_stage;

  typedef struct {
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic        ill;
    logic        chk;   // 0: only illegal/store_data are meaningful
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic        flush;
  logic        out_valid, out_ready;
  logic [3:0]  alu_f;
  logic [31:0] op_a, op_b, store_data;
  logic        illegal;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   stalls = 0;
  int   xfers  = 0;

  logic [3:0] rtab [8] = '{4'd2, 4'd5, 4'd7, 4'd9, 4'd3, 4'd4, 4'd1, 4'd0};

  alu_issue_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_f(alu_f), .op_a(op_a), .op_b(op_b),
    .store_data(store_data), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops and compares whenever the DUT hands over an op.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready && !flush) begin
      xfers++;
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'd0, 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
        chk("store_data", store_data, e.sd);
        if (e.chk) begin
          chk("alu_f", {28'd0, alu_f}, {28'd0, e.f});
          chk("op_a", op_a, e.a);
          chk("op_b", op_b, e.b);
        end
      end
    end
  end

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic b7,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                       input logic [31:0] p, input logic [3:0] ef, input logic [31:0] ea,
                       input logic [31:0] eb, input logic eill, input logic echk);
    exp_t e;
    bit   done = 0;
    opcode = opc; funct3 = f3; funct7b5 = b7;
    rs1_data = r1; rs2_data = r2; imm = im; pc = p;
    in_valid = 1'b1;
    e.f = ef; e.a = ea; e.b = eb; e.sd = r2; e.ill = eill; e.chk = echk;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    opcode = '0; funct3 = '0; funct7b5 = 1'b0;
    rs1_data = '0; rs2_data = '0; imm = '0; pc = '0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_f", {28'd0, alu_f}, 32'd2);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_store_data", store_data, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #5 reset_n = 1'b1;
    @(posedge clk); #1;

    // R-type sweep, rs1=7 rs2=3
    for (int i = 0; i < 8; i++) begin
      issue(7'b0110011, 3'(i), 1'b0, 32'd7, 32'd3, 32'h0, 32'h0, rtab[i], 32'd7, 32'd3, 1'b0, 1'b1);
      if (i == 0)
        issue(7'b0110011, 3'(i), 1'b1, 32'd7, 32'd3, 32'h0, 32'h0, 4'd6, 32'd7, 32'd3, 1'b0, 1'b1);
      else if (i == 5)
        issue(7'b0110011, 3'(i), 1'b1, 32'd7, 32'd3, 32'h0, 32'h0, 4'd8, 32'd7, 32'd3, 1'b0, 1'b1);
      else
        issue(7'b0110011, 3'(i), 1'b1, 32'd7, 32'd3, 32'h0, 32'h0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    end

    // I-type
    issue(7'b0010011, 3'b101, 1'b1, 32'h80000000, 32'h9, 32'h00000405, 32'h0, 4'd8, 32'h80000000, 32'd5, 1'b0, 1'b1);
    issue(7'b0010011, 3'b000, 1'b0, 32'h10, 32'h9, 32'hFFFFFFFF, 32'h0, 4'd2, 32'h10, 32'hFFFFFFFF, 1'b0, 1'b1);
    issue(7'b0010011, 3'b001, 1'b0, 32'h10, 32'h9, 32'h00000023, 32'h0, 4'd5, 32'h10, 32'd3, 1'b0, 1'b1);
    issue(7'b0010011, 3'b001, 1'b1, 32'h10, 32'h9, 32'h00000403, 32'h0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Upper/jump/memory/branch
    issue(7'b0010111, 3'b000, 1'b0, 32'h55, 32'h1, 32'h3000, 32'h100, 4'd2, 32'h100, 32'h3000, 1'b0, 1'b1);
    issue(7'b0110111, 3'b000, 1'b0, 32'h55, 32'h1, 32'h12345000, 32'h100, 4'd2, 32'h0, 32'h12345000, 1'b0, 1'b1);
    issue(7'b1101111, 3'b000, 1'b0, 32'h55, 32'h1, 32'h800, 32'h200, 4'd2, 32'h200, 32'd4, 1'b0, 1'b1);
    issue(7'b0000011, 3'b010, 1'b0, 32'h1000, 32'h2, 32'h8, 32'h0, 4'd2, 32'h1000, 32'h8, 1'b0, 1'b1);
    issue(7'b0100011, 3'b010, 1'b0, 32'h2000, 32'hCAFE, 32'hFFFFFFFC, 32'h0, 4'd2, 32'h2000, 32'hFFFFFFFC, 1'b0, 1'b1);
    issue(7'b1100011, 3'b110, 1'b0, 32'd5, 32'd9, 32'h40, 32'h0, 4'd9, 32'd5, 32'd9, 1'b0, 1'b1);
    issue(7'b1100011, 3'b000, 1'b0, 32'd5, 32'd9, 32'h40, 32'h0, 4'd6, 32'd5, 32'd9, 1'b0, 1'b1);
    issue(7'b1100011, 3'b101, 1'b0, 32'd5, 32'd9, 32'h40, 32'h0, 4'd7, 32'd5, 32'd9, 1'b0, 1'b1);
    issue(7'b1100011, 3'b010, 1'b0, 32'd5, 32'd9, 32'h40, 32'h0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    issue(7'h7F, 3'b000, 1'b0, 32'd5, 32'd9, 32'h40, 32'h44, 4'd2, 32'd0, 32'd0, 1'b1, 1'b1);

    // Backpressure: hold X for 3 cycles while Y waits
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(7'b0110011, 3'b000, 1'b0, 32'h11, 32'h22, 32'h0, 32'h0, 4'd2, 32'h11, 32'h22, 1'b0, 1'b1);
    opcode = 7'b0110011; funct3 = 3'b100; rs1_data = 32'h33; rs2_data = 32'h44; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_alu_f", {28'd0, alu_f}, 32'd2);
      chk("bp_op_a", op_a, 32'h11);
      chk("bp_op_b", op_b, 32'h22);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(7'b0110011, 3'b100, 1'b0, 32'h33, 32'h44, 32'h0, 32'h0, 4'd3, 32'h33, 32'h44, 1'b0, 1'b1);

    // Back-to-back burst must never wait
    stalls = 0;
    issue(7'b0110011, 3'b111, 1'b0, 32'hF0, 32'h3C, 32'h0, 32'h0, 4'd0, 32'hF0, 32'h3C, 1'b0, 1'b1);
    issue(7'b0110011, 3'b110, 1'b0, 32'hF0, 32'h3C, 32'h0, 32'h0, 4'd1, 32'hF0, 32'h3C, 1'b0, 1'b1);
    issue(7'b0010011, 3'b011, 1'b0, 32'h1, 32'h3C, 32'h7, 32'h0, 4'd9, 32'h1, 32'h7, 1'b0, 1'b1);
    issue(7'b1100111, 3'b000, 1'b0, 32'h400, 32'h3C, 32'h10, 32'h0, 4'd2, 32'h400, 32'h10, 1'b0, 1'b1);
    chk("burst_stalls", 32'(stalls), 32'd0);

    // Flush of a held illegal op
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(7'h7F, 3'b000, 1'b0, 32'h1, 32'h2, 32'h3, 32'h4, 4'd2, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("unk_out_valid", {31'd0, out_valid}, 32'd1);
    chk("unk_illegal", {31'd0, illegal}, 32'd1);
    void'(sb.pop_back());
    opcode = 7'b0110011; funct3 = 3'b000; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_illegal", {31'd0, illegal}, 32'd0);
    // Flush while accepting: incoming op is dropped
    out_ready = 1'b1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_in_out_valid", {31'd0, out_valid}, 32'd0);

    // Async reset mid-stream with a held op
    out_ready = 1'b0;
    issue(7'b0110011, 3'b100, 1'b0, 32'h5, 32'h6, 32'h0, 32'h0, 4'd3, 32'h5, 32'h6, 1'b0, 1'b1);
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_alu_f", {28'd0, alu_f}, 32'd2);
    sb.delete();
    #3 reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    issue(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd4, 32'h0, 32'h0, 4'd6, 32'd10, 32'd4, 1'b0, 1'b1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd1);

    // Drain
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
